// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/debug arbiter for a shared 128x16 memory with a bounded lock.
// Define MEM_ARB_RR_EN for round-robin tie-breaks; the default build gives ties to the CPU.
module mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_lock,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              d_req,
    input  logic              d_lock,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              c_gnt,
    output logic              d_gnt,
    output logic              c_rvalid,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0, OWN_C = 2'd1, OWN_D = 2'd2;
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic          tie_c, arb_c, arb_d, at_max, g_c, g_d;
    logic          unused_ok;

`ifdef MEM_ARB_RR_EN
    assign tie_c = last_q;
`else
    assign tie_c = 1'b1;
`endif

    assign arb_c  = c_req & (~d_req | tie_c);
    assign arb_d  = d_req & ~arb_c;
    assign at_max = cnt_q == CNT_MAX;

    // An owner that stops requesting falls through to normal arbitration in the same cycle.
    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        g_c     = 1'b0;
        g_d     = 1'b0;
        if (state_q == OWN_C && c_req) begin
            g_d     = at_max & d_req;
            g_c     = ~g_d;
            state_d = g_c & c_lock ? OWN_C : IDLE;
            cnt_d   = g_c & c_lock ? cnt_q + CW'(!at_max) : '0;
        end else if (state_q == OWN_D && d_req) begin
            g_c     = at_max & c_req;
            g_d     = ~g_c;
            state_d = g_d & d_lock ? OWN_D : IDLE;
            cnt_d   = g_d & d_lock ? cnt_q + CW'(!at_max) : '0;
        end else begin
            g_c     = arb_c;
            g_d     = arb_d;
            state_d = arb_c & c_lock ? OWN_C : arb_d & d_lock ? OWN_D : IDLE;
            cnt_d   = (arb_c & c_lock) | (arb_d & d_lock) ? CW'(1) : '0;
        end
    end

    assign c_gnt      = g_c & rst_n;
    assign d_gnt      = g_d & rst_n;
    assign last_d     = c_gnt ? 1'b0 : d_gnt ? 1'b1 : last_q;
    assign c_rvalid_d = c_gnt & ~c_we;
    assign d_rvalid_d = d_gnt & ~d_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

    // Gating with rst_n drops a read that was in flight when reset arrived.
    assign c_rvalid  = c_rvalid_q & rst_n;
    assign d_rvalid  = d_rvalid_q & rst_n;
    assign c_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_we    = (c_gnt & c_we) | (d_gnt & d_we);
    assign mem_addr  = c_gnt ? c_addr[ADDR_W-1:1] : d_gnt ? d_addr[ADDR_W-1:1] : '0;
    assign mem_wdata = c_gnt ? c_wdata : d_gnt ? d_wdata : '0;
    assign unused_ok = ^{c_addr[0], d_addr[0]};
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, lock sequences and random traffic against a rule-level model.
module tb_mem_arbiter;
    localparam int LOCK_MAX = 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit rst_n; bit cr; bit cl; bit cw; logic [7:0] ca; logic [15:0] cd;
        bit dr; bit dl; bit dw; logic [7:0] da; logic [15:0] dd;
        int mode; bit eg_c; bit eg_d; bit e_we; logic [6:0] e_addr; logic [15:0] e_wd;
        bit e_crv; bit e_drv;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic c_req = 1'b0, c_lock = 1'b0, c_we = 1'b0, d_req = 1'b0, d_lock = 1'b0, d_we = 1'b0;
    logic [7:0] c_addr = '0, d_addr = '0;
    logic [15:0] c_wdata = '0, d_wdata = '0;
    logic c_gnt, d_gnt, c_rvalid, d_rvalid, mem_we;
    logic [15:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [6:0] mem_addr;

    mem_arbiter #(.ADDR_W(8), .DATA_W(16), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_lock(c_lock), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .c_gnt(c_gnt), .d_gnt(d_gnt), .c_rvalid(c_rvalid), .d_rvalid(d_rvalid),
        .c_rdata(c_rdata), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [15:0] mem [128];
    logic [15:0] ref_mem [128];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int checks = 0, failures = 0, step_no = 0;
    int own = 0, cnt = 0, last = 1;
    bit mcrv = 1'b0, mdrv = 1'b0;
    logic [15:0] mrd = '0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", n, step_no, a, e);
        end
    endtask

    task automatic step(input vec_t v);
        int win;
        bit forced, lk, ewe;
        logic [6:0] ea;
        logic [15:0] ew;
        @(negedge clk);
        rst_n = v.rst_n; c_req = v.cr; c_lock = v.cl; c_we = v.cw; c_addr = v.ca; c_wdata = v.cd;
        d_req = v.dr; d_lock = v.dl; d_we = v.dw; d_addr = v.da; d_wdata = v.dd;
        #1;
        forced = 1'b0;
        if (!rst_n) win = 0;
        else if (own == 1 && c_req) begin win = (cnt == LOCK_MAX && d_req) ? 2 : 1; forced = win == 2; end
        else if (own == 2 && d_req) begin win = (cnt == LOCK_MAX && c_req) ? 1 : 2; forced = win == 1; end
        else if (c_req && d_req) win = (RR && last == 0) ? 2 : 1;
        else win = c_req ? 1 : d_req ? 2 : 0;
        ea  = win == 1 ? c_addr[7:1] : win == 2 ? d_addr[7:1] : 7'd0;
        ew  = win == 1 ? c_wdata : win == 2 ? d_wdata : 16'd0;
        ewe = win == 1 ? c_we : win == 2 ? d_we : 1'b0;
        chk("c_gnt", 32'(c_gnt), 32'(win == 1));
        chk("d_gnt", 32'(d_gnt), 32'(win == 2));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_wdata", 32'(mem_wdata), 32'(ew));
        chk("c_rvalid", 32'(c_rvalid), 32'(mcrv & rst_n));
        chk("d_rvalid", 32'(d_rvalid), 32'(mdrv & rst_n));
        if (mcrv && rst_n) chk("c_rdata", 32'(c_rdata), 32'(mrd));
        if (mdrv && rst_n) chk("d_rdata", 32'(d_rdata), 32'(mrd));
        if (v.mode >= 1) begin
            chk("tbl_c_gnt", 32'(c_gnt), 32'(v.eg_c));
            chk("tbl_d_gnt", 32'(d_gnt), 32'(v.eg_d));
        end
        if (v.mode == 2) begin
            chk("tbl_mem_we", 32'(mem_we), 32'(v.e_we));
            chk("tbl_mem_addr", 32'(mem_addr), 32'(v.e_addr));
            chk("tbl_mem_wdata", 32'(mem_wdata), 32'(v.e_wd));
            chk("tbl_c_rvalid", 32'(c_rvalid), 32'(v.e_crv));
            chk("tbl_d_rvalid", 32'(d_rvalid), 32'(v.e_drv));
        end
        @(posedge clk);
        if (!rst_n) begin
            own = 0; cnt = 0; last = 1; mcrv = 1'b0; mdrv = 1'b0;
        end else begin
            mcrv = win == 1 && !c_we;
            mdrv = win == 2 && !d_we;
            if (mcrv || mdrv) mrd = ref_mem[ea];
            if (ewe) ref_mem[ea] = ew;
            if (win != 0) last = win - 1;
            lk = win == 1 ? c_lock : win == 2 ? d_lock : 1'b0;
            if (forced || !lk) begin own = 0; cnt = 0; end
            else if (win == own) cnt = cnt < LOCK_MAX ? cnt + 1 : LOCK_MAX;
            else begin own = win; cnt = 1; end
        end
        step_no++;
    endtask

    vec_t tbl [20];
    vec_t v;
    int dw_idx;
    bit cdone;

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 16'(i * 37 + 5);
            ref_mem[i] = 16'(i * 37 + 5);
        end
        mem[2] = 16'h7312;
        ref_mem[2] = 16'h7312;
        tbl[0]  = '{0,1,0,0,8'h04,16'h0, 1,0,1,8'h02,16'h5, 2, 0,0,0,7'd0,16'h0, 0,0};
        tbl[1]  = '{0,1,0,0,8'h04,16'h0, 0,0,0,8'h00,16'h0, 2, 0,0,0,7'd0,16'h0, 0,0};
        tbl[2]  = '{1,1,0,0,8'h04,16'h0, 0,0,0,8'h00,16'h0, 2, 1,0,0,7'd2,16'h0, 0,0};
        tbl[3]  = '{1,0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 2, 0,0,0,7'd0,16'h0, 1,0};
        tbl[4]  = '{1,0,0,0,8'h00,16'h0, 1,0,1,8'h00,16'hF10A, 2, 0,1,1,7'd0,16'hF10A, 0,0};
        tbl[5]  = '{1,0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 2, 0,0,0,7'd0,16'h0, 0,0};
        tbl[6]  = '{1,1,0,0,8'h10,16'h0, 1,0,0,8'h20,16'h0, 2, 1,0,0,7'd8,16'h0, 0,0};
        tbl[7]  = '{1,1,0,0,8'h10,16'h0, 1,0,0,8'h20,16'h0, 2, !RR,RR,0,RR ? 7'd16 : 7'd8,16'h0, 1,0};
        tbl[8]  = '{1,1,0,0,8'h10,16'h0, 1,0,0,8'h20,16'h0, 2, 1,0,0,7'd8,16'h0, !RR,RR};
        tbl[9]  = '{1,1,0,0,8'h10,16'h0, 1,0,0,8'h20,16'h0, 2, !RR,RR,0,RR ? 7'd16 : 7'd8,16'h0, 1,0};
        tbl[10] = '{1,0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 2, 0,0,0,7'd0,16'h0, !RR,RR};
        tbl[11] = '{1,0,0,0,8'h00,16'h0, 1,1,0,8'h08,16'h0, 2, 0,1,0,7'd4,16'h0, 0,0};
        tbl[12] = '{1,1,0,0,8'h0A,16'h0, 0,0,0,8'h00,16'h0, 2, 1,0,0,7'd5,16'h0, 0,1};
        tbl[13] = '{1,0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 2, 0,0,0,7'd0,16'h0, 1,0};
        tbl[14] = '{1,1,0,0,8'h04,16'h0, 0,0,0,8'h00,16'h0, 2, 1,0,0,7'd2,16'h0, 0,0};
        tbl[15] = '{0,1,0,1,8'h04,16'h9, 0,0,0,8'h00,16'h0, 2, 0,0,0,7'd0,16'h0, 0,0};
        tbl[16] = '{1,0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 2, 0,0,0,7'd0,16'h0, 0,0};
        tbl[17] = '{1,0,0,0,8'h00,16'h0, 1,0,0,8'h07,16'h0, 2, 0,1,0,7'd3,16'h0, 0,0};
        tbl[18] = '{1,1,0,1,8'hFF,16'h1234, 0,0,0,8'h00,16'h0, 2, 1,0,1,7'h7F,16'h1234, 0,1};
        tbl[19] = '{1,0,0,0,8'h00,16'h0, 0,0,0,8'h00,16'h0, 2, 0,0,0,7'd0,16'h0, 0,0};
        foreach (tbl[i]) step(tbl[i]);

        // Debug locks 10 writes, CPU waits from cycle 2: 8 debug grants, forced CPU grant, then debug again.
        v = tbl[19];
        v.mode = 1;
        dw_idx = 0;
        cdone = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            v.dr = 1; v.dw = 1; v.dl = dw_idx < 9; v.da = 8'(8'h40 + dw_idx * 2); v.dd = 16'(16'hA000 + dw_idx);
            v.cr = k >= 2 && !cdone; v.cw = 0; v.ca = 8'h06;
            v.eg_c = k == 9; v.eg_d = k != 9;
            step(v);
            if (k == 9) cdone = 1'b1;
            else dw_idx++;
        end
        // Lock count saturates while the CPU is idle, then the late CPU request is forced through.
        for (int k = 1; k <= 12; k++) begin
            v.dr = 1; v.dw = 1; v.dl = k < 12; v.da = 8'(8'h60 + k * 2); v.dd = 16'(16'hB000 + k);
            v.cr = k == 11; v.cw = 1; v.ca = 8'h0C; v.cd = 16'hC0DE;
            v.eg_c = k == 11; v.eg_d = k != 11;
            step(v);
        end

        for (int i = 0; i < 600; i++) begin
            v.rst_n = $urandom_range(0, 49) != 0;
            v.cr = $urandom_range(0, 2) != 0; v.cl = 1'($urandom_range(0, 1)); v.cw = 1'($urandom_range(0, 1));
            v.ca = 8'($urandom); v.cd = 16'($urandom);
            v.dr = $urandom_range(0, 2) != 0; v.dl = 1'($urandom_range(0, 1)); v.dw = 1'($urandom_range(0, 1));
            v.da = 8'($urandom); v.dd = 16'($urandom);
            v.mode = 0;
            step(v);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port 128×16 word memory between the CPU and the debug/program loader port. Each cycle it grants at most one requester, drives the memory's write-enable, word address and write data from the winner, and returns read data to that requester one cycle later with a valid strobe. A lock input lets one requester hold the memory for multi-word sequences, e.g. the loader writing a program image before the CPU fetches. A bounded lock counter guarantees the other port is never starved.

## Interface
- `ADDR_W`, 8, byte address width seen by requesters
- `DATA_W`, 16, data word width
- `LOCK_MAX`, 8, maximum consecutive locked grants before a forced release
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `c_req` / `d_req`  in  1  CPU / debug request
- `c_lock` / `d_lock`  in  1  hold grant after the current access
- `c_we` / `d_we`  in  1  write (1) or read (0)
- `c_addr` / `d_addr`  in  ADDR_W  byte address; bit 0 ignored
- `c_wdata` / `d_wdata`  in  DATA_W  write data
- `c_gnt` / `d_gnt`  out  1  access accepted this cycle (combinational)
- `c_rvalid` / `d_rvalid`  out  1  read data valid, one cycle after a read grant
- `c_rdata` / `d_rdata`  out  DATA_W  `mem_rdata`, meaningful only with rvalid
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W-1  word address = winner's `addr[ADDR_W-1:1]`
- `mem_wdata`  out  DATA_W  winner's write data
- `mem_rdata`  in  DATA_W  memory read data, registered (valid the cycle after the address)

## Operation
- States: IDLE, OWN_C, OWN_D. Reset -> IDLE, `last` = D, lock count = 0, both rvalid = 0.
- IDLE: only one req -> grant it; both -> tie-break (see Configuration). Granted with its lock = 1 -> OWN_x, count = 1; otherwise stay IDLE and update `last`.
- OWN_x: owner x is the only port that can be granted while it requests. Grant x if x_req; count++ each locked grant.
- Leave OWN_x -> IDLE when x_lock = 0 on a granted cycle (the access completes), x_req = 0 (no grant that cycle; the other port arbitrates normally the same cycle), or count = LOCK_MAX while the other port requests (x not granted, other port granted, count cleared).
- If count reaches LOCK_MAX and the other port is idle, the owner keeps the grant and count saturates.
- Outputs follow the granted port. With no grant, `mem_we` = 0, `mem_addr`/`mem_wdata` = 0.
- Read grant: the rvalid register of that port is 1 for exactly the next cycle. Write grant: no rvalid.
- Back-to-back reads from alternating ports give rvalid on alternating ports, each aligned to its own data.

## Timing
- Grant is combinational from req and registered state; the memory access occurs on the rising edge that ends the grant cycle.
- Read latency is 1 cycle from grant to rvalid. Write is committed at the grant edge.
- Throughput is one access per cycle. No bubble between ports.
- Requester keeps req/we/addr/wdata stable until it sees gnt.
- `rst_n` low at an edge: state -> IDLE and rvalid -> 0 next cycle. While `rst_n` is low, gnt = 0 and `mem_we` = 0 combinationally. An in-flight read's rvalid is dropped.
- Reset values: gnt 0/0, rvalid 0/0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.

## Configuration
- `MEM_ARB_RR_EN` defined: IDLE ties go to the port not equal to `last`, giving round-robin alternation.
- `MEM_ARB_RR_EN` undefined: IDLE ties always go to the CPU (fixed priority). `last` is still tracked but unused. Lock and forced-release behaviour is identical in both builds.

## Test plan
- Reset, then single CPU read of byte addr 0x04 with memory word 2 = 0x7312 -> `c_gnt` same cycle, `mem_addr` = 2, `c_rvalid` next cycle with `c_rdata` = 0x7312, `d_rvalid` stays 0.
- Debug writes 0xF10A to addr 0x00 while the CPU is idle -> `d_gnt`, `mem_we` = 1, `mem_addr` = 0, `mem_wdata` = 0xF10A; no rvalid.
- Both request reads continuously for 4 cycles. With RR the grant sequence is C,D,C,D; without RR it is C,C,C,C. rvalid tracks the same port sequence delayed by 1.
- Debug locks and writes 10 words while the CPU requests throughout (LOCK_MAX = 8) -> 8 `d_gnt`, then one `c_gnt`, then debug re-arbitrates.
- `rst_n` low for one cycle immediately after a CPU read grant -> `c_rvalid` stays 0, state IDLE, next request is granted normally.
